// File: rtl/xdisp_scan_ctrl_pkg.sv
// xdisp_scan_ctrl_pkg: shared segment codes, message/state encodings and data word field offsets.
package xdisp_scan_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  typedef enum logic [1:0] {MSG_NUM, MSG_OP, MSG_VAL, MSG_ERR} msg_t;
  localparam int OFF_SGN = 0;
  localparam int OFF_MSG = 1;
  localparam int OFF_DOT = 3;
  localparam int OFF_BLINK = 6;
  localparam int DOT_W = 3;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_O = 8'hC0;
  localparam logic [7:0] SEG_P = 8'h8C;
  localparam logic [7:0] SEG_V = 8'hC1;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_L = 8'hC7;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_R = 8'hAF;
  localparam logic [79:0] SEG_DIG = {8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    return d < 4'd10 ? SEG_DIG[8*d +: 8] : SEG_BLANK;
  endfunction
endpackage

// File: rtl/xdisp_scan_ctrl_xbin2bcd.sv
// xbin2bcd: iterative double-dabble, start loads the value, done marks the cycle of the final shift.
module xbin2bcd #(
  parameter int BIN_W = 8,
  parameter int N_BCD = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic               done,
  output logic [4*N_BCD-1:0] bcd
);
  localparam int BW = 4*N_BCD;
  localparam int CW = $clog2(BIN_W+1);
  logic [BW+BIN_W-1:0] sr, sr_nx;
  logic [CW-1:0] cnt;
  always_comb begin
    sr_nx = sr;
    for (int i = 0; i < N_BCD; i++)
      if (sr_nx[BIN_W+4*i +: 4] >= 4'd5) sr_nx[BIN_W+4*i +: 4] = sr_nx[BIN_W+4*i +: 4] + 4'd3;
    sr_nx = sr_nx << 1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      cnt <= '0;
    end else if (start) begin
      sr <= {{BW{1'b0}}, bin};
      cnt <= CW'(BIN_W);
    end else if (cnt != '0) begin
      sr <= sr_nx;
      cnt <= cnt - CW'(1);
    end
  assign done = cnt == CW'(1);
  assign bcd = sr[BIN_W +: BW];
endmodule

// File: rtl/xdisp_scan_ctrl.sv
// xdisp_scan_ctrl: memory-mapped N-digit 7-segment controller with buffered updates and scan mux.
// Optional blink gating when XDISP_BLINK_EN is defined.
module xdisp_scan_ctrl
  import xdisp_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W = 8,
  parameter int SCAN_DIV = 50000,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  logic                we,
  input  logic [DATA_W-1:0]   data_in,
  output logic                busy,
  output logic [N_DIGITS-1:0] disp_sel,
  output logic [7:0]          disp_value
);
  localparam int NB = N_DIGITS-1;
  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  state_t st, st_nx;
  msg_t src_msg, msg_r;
  logic wr, go, start, done, pv, sgn_r, seen, wrap, blank_now, unused_src;
  logic [DATA_W-1:0] pend, src;
  logic [DOT_W-1:0] dot_r;
  logic [4*NB-1:0] bcd;
  logic [4*N_DIGITS-1:0] bcdx;
  logic [N_DIGITS-1:0] shown, minus;
  logic [7:0] dig [N_DIGITS];
  logic [7:0] pat [N_DIGITS];
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  assign wr = sel & we;
  assign src = wr ? data_in : pend;
  assign src_msg = msg_t'(src[BIN_W+OFF_MSG +: 2]);
  assign go = (st != CONV) & (wr | pv);
  assign start = go & (src_msg == MSG_NUM);
  assign busy = st != IDLE;
  assign unused_src = ^src;
  always_comb st_nx = go ? (start ? CONV : LOAD) : (st == CONV) ? (done ? LOAD : CONV) : IDLE;
  // A write arriving in LOAD is newer than anything pending, so it is taken directly.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      pv <= 1'b0;
      pend <= '0;
      msg_r <= MSG_NUM;
      sgn_r <= 1'b0;
      dot_r <= '0;
    end else begin
      st <= st_nx;
      if (go) pv <= 1'b0;
      else if (wr) begin
        pv <= 1'b1;
        pend <= data_in;
      end
      if (go) begin
        msg_r <= src_msg;
        sgn_r <= src[BIN_W+OFF_SGN];
        dot_r <= src[BIN_W+OFF_DOT +: DOT_W];
      end
    end
  xbin2bcd #(.BIN_W(BIN_W), .N_BCD(NB)) u_bcd (
    .clk(clk), .rst(rst), .start(start), .bin(src[BIN_W-1:0]), .done(done), .bcd(bcd)
  );
  assign bcdx = {4'd0, bcd};
  assign minus = {shown[N_DIGITS-2:0], 1'b0} & ~shown & {N_DIGITS{sgn_r}};
  always_comb begin
    seen = 1'b0;
    shown = '0;
    for (int i = NB-1; i >= 0; i--) begin
      seen = seen | (bcdx[4*i +: 4] != 4'd0) | (i == 0);
      shown[i] = seen;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (msg_r == MSG_NUM)
        pat[i] = shown[i] ? seg_digit(bcdx[4*i +: 4]) : minus[i] ? SEG_MINUS : SEG_BLANK;
      else
        pat[i] = i == 0 ? (msg_r == MSG_OP ? SEG_P : msg_r == MSG_VAL ? SEG_L : SEG_R) :
                 i == 1 ? (msg_r == MSG_OP ? SEG_O : msg_r == MSG_VAL ? SEG_A : SEG_R) :
                 i == 2 ? (msg_r == MSG_OP ? SEG_BLANK : msg_r == MSG_VAL ? SEG_V : SEG_E) : SEG_BLANK;
      if (int'(dot_r) == i+1) pat[i][7] = 1'b0;
    end
  end
  assign wrap = cnt == CW'(SCAN_DIV-1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dig <= '{default: SEG_BLANK};
      cnt <= '0;
      idx <= '0;
      disp_sel <= '1;
      disp_value <= SEG_BLANK;
    end else begin
      if (st == LOAD) dig <= pat;
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) idx <= idx == IW'(N_DIGITS-1) ? '0 : idx + IW'(1);
      disp_sel <= blank_now ? '1 : ~(N_DIGITS'(1) << idx);
      disp_value <= dig[idx];
    end
`ifdef XDISP_BLINK_EN
  logic [23:0] bctr;
  logic blink_r, blink_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bctr <= '0;
      blink_r <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      bctr <= bctr + 24'd1;
      if (go) blink_r <= src[BIN_W+OFF_BLINK];
      if (st == LOAD) blink_q <= blink_r;
    end
  assign blank_now = blink_q & bctr[23];
`else
  assign blank_now = 1'b0;
`endif
endmodule
